// File: rtl/usb2_pkg.sv
// Shared USB 2.0 definitions for the EP0 control initiator:
// PIDs, request codes, status codes and FSM encoding.
package usb2_pkg;

   localparam logic [3:0] PID_OUT   = 4'h1;
   localparam logic [3:0] PID_IN    = 4'h9;
   localparam logic [3:0] PID_SETUP = 4'hD;
   localparam logic [3:0] PID_DATA0 = 4'h3;
   localparam logic [3:0] PID_DATA1 = 4'hB;
   localparam logic [3:0] PID_ACK   = 4'h2;
   localparam logic [3:0] PID_NAK   = 4'hA;
   localparam logic [3:0] PID_STALL = 4'hE;

   localparam logic [7:0] REQ_GET_STATUS    = 8'h00;
   localparam logic [7:0] REQ_SET_ADDR      = 8'h05;
   localparam logic [7:0] REQ_GET_DESCR     = 8'h06;
   localparam logic [7:0] REQ_GET_CONFIG    = 8'h08;
   localparam logic [7:0] REQ_SET_CONFIG    = 8'h09;
   localparam logic [7:0] REQ_SET_INTERFACE = 8'h0B;

   // bmRequestType: [7] direction, [6:5] type, [4:0] recipient
   localparam logic       RT_DIR_OUT = 1'b0;
   localparam logic       RT_DIR_IN  = 1'b1;
   localparam logic [1:0] RT_STD     = 2'd0;
   localparam logic [1:0] RT_CLASS   = 2'd1;
   localparam logic [1:0] RT_VENDOR  = 2'd2;
   localparam logic [4:0] RT_DEVICE  = 5'd0;
   localparam logic [4:0] RT_IFACE   = 5'd1;
   localparam logic [4:0] RT_EP      = 5'd2;

   typedef enum logic [1:0] {
      ST_OK     = 2'd0,
      ST_TO_RDY = 2'd1,
      ST_TO_ACK = 2'd2,
      ST_NO_RSP = 2'd3
   } status_e;

   typedef enum logic [3:0] {
      S_IDLE, S_WAIT_RDY, S_WRITE, S_COMMIT,
      S_WAIT_ACKLO, S_WAIT_RSP, S_LATCH, S_READ,
      S_ARM, S_ARM_ACKLO, S_ARM_HDLO, S_DONE
   } state_e;

   typedef struct packed {
      logic [7:0]  rtype;
      logic [7:0]  code;
      logic [15:0] val;
      logic [15:0] idx;
      logic [15:0] len;
   } setup_t;

   // Bytes 8 and 9 are CRC placeholders and stay zero
   function automatic logic [7:0] setup_byte(setup_t s, logic [3:0] i);
      logic [7:0] b;
      case (i)
         4'd0:    b = s.rtype;
         4'd1:    b = s.code;
         4'd2:    b = s.val[7:0];
         4'd3:    b = s.val[15:8];
         4'd4:    b = s.idx[7:0];
         4'd5:    b = s.idx[15:8];
         4'd6:    b = s.len[7:0];
         4'd7:    b = s.len[15:8];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/usb2_ep0_ctrl_initiator_if.sv
// EP0 buffer interface: input buffer write/commit and
// output buffer read/arm, as seen from the host initiator.
interface usb2_ep0_ctrl_initiator_if;

   logic [8:0] buf_in_addr;
   logic [7:0] buf_in_data;
   logic       buf_in_wren;
   logic       buf_in_ready;
   logic       buf_in_commit;
   logic [9:0] buf_in_commit_len;
   logic       buf_in_commit_ack;
   logic [8:0] buf_out_addr;
   logic [7:0] buf_out_q;
   logic [9:0] buf_out_len;
   logic       buf_out_hasdata;
   logic       buf_out_arm;
   logic       buf_out_arm_ack;

   modport master (
      output buf_in_addr, buf_in_data, buf_in_wren,
      output buf_in_commit, buf_in_commit_len,
      output buf_out_addr, buf_out_arm,
      input  buf_in_ready, buf_in_commit_ack,
      input  buf_out_q, buf_out_len,
      input  buf_out_hasdata, buf_out_arm_ack
   );

   modport slave (
      input  buf_in_addr, buf_in_data, buf_in_wren,
      input  buf_in_commit, buf_in_commit_len,
      input  buf_out_addr, buf_out_arm,
      output buf_in_ready, buf_in_commit_ack,
      output buf_out_q, buf_out_len,
      output buf_out_hasdata, buf_out_arm_ack
   );

endinterface

// File: rtl/usb2_strobe_hold.sv
// Level strobe held for at least HOLD_CYC cycles and until ack is
// seen; gives up with tmo after TIMEOUT_CYC cycles.
module usb2_strobe_hold
   import usb2_pkg::*;
#(
   parameter int HOLD_CYC    = 4,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic go,
   input  logic ack,
   output logic strobe,
   output logic fin,
   output logic tmo
);

   localparam int HW = $clog2(HOLD_CYC + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [HW-1:0] hcnt;
   logic [TW-1:0] tcnt;
   logic          seen;
   logic          held;

   assign held = (hcnt == HW'(HOLD_CYC - 1));
   assign fin  = strobe & (seen | ack) & held;
   assign tmo  = strobe & ~fin & (tcnt == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         strobe <= 1'b0;
         hcnt   <= '0;
         tcnt   <= '0;
         seen   <= 1'b0;
      end else if (go) begin
         strobe <= 1'b1;
         hcnt   <= '0;
         tcnt   <= '0;
         seen   <= 1'b0;
      end else if (strobe) begin
         if (fin || tmo) strobe <= 1'b0;
         if (!held) hcnt <= hcnt + 1'b1;
         seen <= seen | ack;
         tcnt <= tcnt + 1'b1;
      end
   end

endmodule

// File: rtl/usb2_ep0_ctrl_initiator.sv
// Host-side EP0 control initiator: writes a SETUP packet, commits,
// reads back the response and re-arms the endpoint.
module usb2_ep0_ctrl_initiator
   import usb2_pkg::*;
#(
   parameter int RD_LAT      = 2,
   parameter int TIMEOUT_CYC = 1024,
   parameter int HOLD_CYC    = 4
) (
   input  logic        phy_clk,
   input  logic        reset,
   input  logic        req_start,
   input  logic [7:0]  req_type,
   input  logic [7:0]  req_code,
   input  logic [15:0] req_val,
   input  logic [15:0] req_idx,
   input  logic [15:0] req_len,
   output logic        req_busy,
   usb2_ep0_ctrl_initiator_if.master ep0,
   output logic        rsp_valid,
   output logic [7:0]  rsp_data,
   output logic [9:0]  rsp_idx,
   output logic        done,
   output logic [1:0]  status,
   output logic [9:0]  rsp_count
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   state_e        state, state_n;
   status_e       st_q, st_val;
   logic          st_set;
   setup_t        req;
   logic [3:0]    wcnt;
   logic [TW-1:0] tcnt;
   logic [4:0]    rcnt;
   logic [9:0]    n, ra, rsp_cnt;
   logic          pipe_v [RD_LAT];
   logic [9:0]    pipe_i [RD_LAT];
   logic          issue, tmo_hit, start;
   logic          cm_go, cm_fin, cm_tmo;
   logic          am_go, am_fin, am_tmo;

   assign start   = (state == S_IDLE) && req_start;
   assign issue   = (state == S_READ) && (ra < n);
   assign tmo_hit = (tcnt == TW'(TIMEOUT_CYC - 1));

   assign req_busy  = (state != S_IDLE) && (state != S_DONE);
   assign done      = (state == S_DONE);
   assign status    = st_q;
   assign rsp_count = rsp_cnt;

   assign ep0.buf_in_wren       = (state == S_WRITE);
   assign ep0.buf_in_addr       = {5'd0, wcnt};
   assign ep0.buf_in_data       = setup_byte(req, wcnt);
   assign ep0.buf_in_commit_len = 10'd10;
   assign ep0.buf_out_addr      = ra[8:0];

   usb2_strobe_hold #(.HOLD_CYC(HOLD_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) u_commit (
      .clk(phy_clk), .rst(reset), .go(cm_go), .ack(ep0.buf_in_commit_ack),
      .strobe(ep0.buf_in_commit), .fin(cm_fin), .tmo(cm_tmo)
   );

   usb2_strobe_hold #(.HOLD_CYC(HOLD_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) u_arm (
      .clk(phy_clk), .rst(reset), .go(am_go), .ack(ep0.buf_out_arm_ack),
      .strobe(ep0.buf_out_arm), .fin(am_fin), .tmo(am_tmo)
   );

   always_comb begin
      state_n = state;
      st_set  = 1'b0;
      st_val  = ST_OK;
      cm_go   = 1'b0;
      am_go   = 1'b0;
      unique case (state)
         S_IDLE:
            if (req_start) state_n = S_WAIT_RDY;
         S_WAIT_RDY:
            if (ep0.buf_in_ready) state_n = S_WRITE;
            else if (tmo_hit) begin
               state_n = S_DONE; st_set = 1'b1; st_val = ST_TO_RDY;
            end
         S_WRITE:
            if (wcnt == 4'd9) begin state_n = S_COMMIT; cm_go = 1'b1; end
         S_COMMIT:
            if (cm_fin) state_n = S_WAIT_ACKLO;
            else if (cm_tmo) begin
               state_n = S_DONE; st_set = 1'b1; st_val = ST_TO_ACK;
            end
         S_WAIT_ACKLO:
            if (!ep0.buf_in_commit_ack) state_n = S_WAIT_RSP;
            else if (tmo_hit) begin
               state_n = S_DONE; st_set = 1'b1; st_val = ST_TO_ACK;
            end
         // ready back without data for 16 cycles means EP0 refused it
         S_WAIT_RSP:
            if (ep0.buf_out_hasdata) state_n = S_LATCH;
            else if ((ep0.buf_in_ready && rcnt == 5'd15) || tmo_hit) begin
               state_n = S_DONE; st_set = 1'b1; st_val = ST_NO_RSP;
            end
         S_LATCH:
            if (ep0.buf_out_len == 10'd0) begin
               state_n = S_ARM; am_go = 1'b1;
            end else state_n = S_READ;
         S_READ:
            if (rsp_cnt == n) begin state_n = S_ARM; am_go = 1'b1; end
         S_ARM:
            if (am_fin) state_n = S_ARM_ACKLO;
            else if (am_tmo) begin
               state_n = S_DONE; st_set = 1'b1; st_val = ST_TO_ACK;
            end
         S_ARM_ACKLO:
            if (!ep0.buf_out_arm_ack) state_n = S_ARM_HDLO;
            else if (tmo_hit) begin
               state_n = S_DONE; st_set = 1'b1; st_val = ST_TO_ACK;
            end
         S_ARM_HDLO:
            if (!ep0.buf_out_hasdata) state_n = S_DONE;
            else if (tmo_hit) begin
               state_n = S_DONE; st_set = 1'b1; st_val = ST_TO_ACK;
            end
         S_DONE:
            state_n = S_IDLE;
         default:
            state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge phy_clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         st_q      <= ST_OK;
         req       <= '0;
         wcnt      <= '0;
         tcnt      <= '0;
         rcnt      <= '0;
         n         <= '0;
         ra        <= '0;
         rsp_cnt   <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_idx   <= '0;
         for (int k = 0; k < RD_LAT; k++) begin
            pipe_v[k] <= 1'b0;
            pipe_i[k] <= '0;
         end
      end else begin
         state <= state_n;
         tcnt  <= (state_n != state) ? '0 : tcnt + 1'b1;
         wcnt  <= (state == S_WRITE) ? wcnt + 1'b1 : 4'd0;
         if (state == S_WAIT_RSP && ep0.buf_in_ready && !ep0.buf_out_hasdata)
            rcnt <= rcnt + 1'b1;
         else
            rcnt <= '0;
         if (start) begin
            req     <= '{req_type, req_code, req_val, req_idx, req_len};
            st_q    <= ST_OK;
            rsp_cnt <= '0;
         end else if (st_set) st_q <= st_val;
         if (state == S_LATCH) begin
            n  <= ep0.buf_out_len;
            ra <= '0;
         end else if (issue) ra <= ra + 1'b1;
         // address tag travels alongside the RD_LAT-cycle read
         pipe_v[0] <= issue;
         pipe_i[0] <= ra;
         for (int k = 1; k < RD_LAT; k++) begin
            pipe_v[k] <= pipe_v[k-1];
            pipe_i[k] <= pipe_i[k-1];
         end
         rsp_valid <= pipe_v[RD_LAT-1];
         if (pipe_v[RD_LAT-1]) begin
            rsp_data <= ep0.buf_out_q;
            rsp_idx  <= pipe_i[RD_LAT-1];
            rsp_cnt  <= rsp_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_usb2_ep0_ctrl_initiator.sv
// Scoreboard bench for usb2_ep0_ctrl_initiator against a small
// behavioural EP0 endpoint model.
module tb_usb2_ep0_ctrl_initiator;

   logic        phy_clk = 1'b0;
   logic        reset   = 1'b1;
   logic        req_start = 1'b0;
   logic [7:0]  req_type = '0, req_code = '0;
   logic [15:0] req_val = '0, req_idx = '0, req_len = '0;
   logic        req_busy, rsp_valid, done;
   logic [7:0]  rsp_data;
   logic [9:0]  rsp_idx, rsp_count;
   logic [1:0]  status;

   always #5 phy_clk = ~phy_clk;

   usb2_ep0_ctrl_initiator_if ep0 ();

   usb2_ep0_ctrl_initiator dut (
      .phy_clk(phy_clk), .reset(reset), .req_start(req_start),
      .req_type(req_type), .req_code(req_code), .req_val(req_val),
      .req_idx(req_idx), .req_len(req_len), .req_busy(req_busy),
      .ep0(ep0), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .rsp_idx(rsp_idx), .done(done), .status(status),
      .rsp_count(rsp_count)
   );

   int nvec = 0, nerr = 0;
   int done_seen = 0, rsp_seen = 0, arm_rise = 0, clen = 0;
   logic arm_d = 1'b0;
   logic [16:0] exp_wr[$];
   logic [17:0] exp_rsp[$];
   logic [11:0] exp_done[$];

   logic [7:0] dev_desc [18];
   logic [7:0] cfg_desc [32];

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic bad(string name, logic [63:0] act);
      nvec++;
      nerr++;
      $display("FAIL %s: got %0h want nothing", name, act);
   endtask

   // ---------------- EP0 endpoint model ----------------
   logic       m_ready, c_ack, a_ack, hasdata, block_rdy = 1'b0;
   logic [9:0] out_len;
   logic [1:0] dsel;
   logic [6:0] dev_addr;
   logic [7:0] mem_in [10];
   logic [7:0] q1, q2;
   logic [3:0] mst;
   int         dly;

   assign ep0.buf_in_ready      = m_ready & ~block_rdy;
   assign ep0.buf_in_commit_ack = c_ack;
   assign ep0.buf_out_arm_ack   = a_ack;
   assign ep0.buf_out_hasdata   = hasdata;
   assign ep0.buf_out_len       = out_len;
   assign ep0.buf_out_q         = q2;

   function automatic logic [7:0] desc_at(logic [1:0] s, logic [8:0] a);
      if (s == 2'd1 && a < 18) return dev_desc[a];
      if (s == 2'd2 && a < 32) return cfg_desc[a];
      return 8'hEE;
   endfunction

   function automatic logic [9:0] min_len(logic [15:0] wl, logic [9:0] dl);
      return (wl < 16'(dl)) ? wl[9:0] : dl;
   endfunction

   always @(posedge phy_clk) begin
      q1 <= desc_at(dsel, ep0.buf_out_addr);
      q2 <= q1;
   end

   always @(posedge phy_clk or posedge reset) begin
      if (reset) begin
         m_ready <= 1'b1; c_ack <= 1'b0; a_ack <= 1'b0;
         hasdata <= 1'b0; out_len <= '0; mst <= '0; dly <= 0;
         dsel <= '0; dev_addr <= '0;
      end else begin
         if (ep0.buf_in_wren && ep0.buf_in_addr < 10)
            mem_in[ep0.buf_in_addr[3:0]] <= ep0.buf_in_data;
         case (mst)
            4'd0: if (ep0.buf_in_commit) begin
               m_ready <= 1'b0; dly <= 0; mst <= 4'd1;
            end
            4'd1: begin
               dly <= dly + 1;
               if (dly == 2) begin c_ack <= 1'b1; mst <= 4'd2; end
            end
            4'd2: if (!ep0.buf_in_commit) begin
               c_ack <= 1'b0; dly <= 0; mst <= 4'd3;
            end
            4'd3: begin
               dly <= dly + 1;
               if (dly == 2) begin
                  if (mem_in[1] == 8'h06 && (mem_in[3] == 8'h01 || mem_in[3] == 8'h02)) begin
                     dsel    <= mem_in[3][1:0];
                     out_len <= min_len({mem_in[7], mem_in[6]},
                                        mem_in[3] == 8'h01 ? 10'd18 : 10'd32);
                     hasdata <= 1'b1; mst <= 4'd4;
                  end else if (mem_in[1] == 8'h05) begin
                     dev_addr <= mem_in[2][6:0];
                     out_len  <= '0; hasdata <= 1'b1; mst <= 4'd4;
                  end else begin
                     m_ready <= 1'b1; mst <= 4'd0;
                  end
               end
            end
            4'd4: if (ep0.buf_out_arm) begin dly <= 0; mst <= 4'd5; end
            4'd5: begin
               dly <= dly + 1;
               if (dly == 1) begin a_ack <= 1'b1; mst <= 4'd6; end
            end
            4'd6: if (!ep0.buf_out_arm) begin
               a_ack <= 1'b0; dly <= 0; mst <= 4'd7;
            end
            4'd7: begin
               dly <= dly + 1;
               if (dly == 2) begin
                  hasdata <= 1'b0; m_ready <= 1'b1; mst <= 4'd0;
               end
            end
            default: mst <= 4'd0;
         endcase
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge phy_clk) begin
      logic [17:0] e;
      if (reset) begin
         clen  = 0;
         arm_d = 1'b0;
      end else begin
         if (ep0.buf_in_wren) begin
            if (exp_wr.size() == 0) bad("wr_unexp", {ep0.buf_in_addr, ep0.buf_in_data});
            else chk("wr", {ep0.buf_in_addr, ep0.buf_in_data}, exp_wr.pop_front());
         end
         if (rsp_valid) begin
            rsp_seen++;
            if (exp_rsp.size() == 0) bad("rsp_unexp", {rsp_idx, rsp_data});
            else begin
               e = exp_rsp.pop_front();
               chk("rsp", {rsp_idx, rsp_data}, e);
            end
         end
         if (done) begin
            done_seen++;
            if (exp_done.size() == 0) bad("done_unexp", {status, rsp_count});
            else chk("done_stat_cnt", {status, rsp_count}, exp_done.pop_front());
         end
         if (ep0.buf_in_commit) begin
            if (clen == 0) chk("commit_len", ep0.buf_in_commit_len, 10);
            clen++;
         end else if (clen > 0) begin
            chk("commit_hold_ge4", clen >= 4, 1);
            clen = 0;
         end
         if (ep0.buf_out_arm && !arm_d) arm_rise++;
         arm_d = ep0.buf_out_arm;
      end
   end

   // ---------------- stimulus ----------------
   task automatic check_zero(string tag);
      chk({tag, "_ctl"}, {req_busy, done, rsp_valid, status, rsp_count}, 0);
      chk({tag, "_rsp"}, {rsp_data, rsp_idx}, 0);
      chk({tag, "_buf"}, {ep0.buf_in_wren, ep0.buf_in_addr, ep0.buf_in_data,
          ep0.buf_in_commit, ep0.buf_out_arm, ep0.buf_out_addr}, 0);
   endtask

   task automatic pulse(logic [7:0] rt, cd, logic [15:0] v, ix, ln);
      @(posedge phy_clk); #1;
      req_type = rt; req_code = cd; req_val = v; req_idx = ix; req_len = ln;
      req_start = 1'b1;
      @(posedge phy_clk); #1;
      req_start = 1'b0;
   endtask

   task automatic push_exp(logic [7:0] rt, cd, logic [15:0] v, ix, ln,
                           int sel, int nb, bit writes);
      logic [7:0] b [10];
      b = '{rt, cd, v[7:0], v[15:8], ix[7:0], ix[15:8], ln[7:0], ln[15:8], 8'h00, 8'h00};
      if (writes) for (int i = 0; i < 10; i++) exp_wr.push_back({9'(i), b[i]});
      for (int i = 0; i < nb; i++)
         exp_rsp.push_back({10'(i), sel == 1 ? dev_desc[i] : cfg_desc[i]});
   endtask

   task automatic xfer(string nm, logic [7:0] rt, cd, logic [15:0] v, ix, ln,
                       int sel, int nb, logic [1:0] est, int arms,
                       bit writes, bit poke);
      int d0, a0;
      push_exp(rt, cd, v, ix, ln, sel, nb, writes);
      exp_done.push_back({est, 10'(nb)});
      d0 = done_seen;
      a0 = arm_rise;
      pulse(rt, cd, v, ix, ln);
      chk({nm, "_busy"}, req_busy, 1);
      if (poke) begin
         repeat (100) @(posedge phy_clk);
         pulse(8'h80, 8'h06, 16'h0100, 16'h0000, 16'h0012);
      end
      for (int c = 0; c < 3000 && done_seen == d0; c++) @(posedge phy_clk);
      if (done_seen == d0) bad({nm, "_done_timeout"}, 0);
      repeat (3) @(posedge phy_clk);
      #1;
      chk({nm, "_idle"}, req_busy, 0);
      chk({nm, "_status_hold"}, status, est);
      chk({nm, "_arms"}, arm_rise - a0, arms);
   endtask

   initial begin
      int d0, r0;
      dev_desc = '{8'h12, 8'h01, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h40, 8'h34,
                   8'h12, 8'h78, 8'h56, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h01};
      for (int i = 0; i < 32; i++) cfg_desc[i] = 8'h40 + 8'(i);
      cfg_desc[0:8] = '{8'h09, 8'h02, 8'h20, 8'h00, 8'h01, 8'h01, 8'h00, 8'h80, 8'h32};

      repeat (3) @(posedge phy_clk);
      #1;
      check_zero("reset");
      reset = 1'b0;
      repeat (2) @(posedge phy_clk);

      xfer("get_dev", 8'h80, 8'h06, 16'h0100, 16'h0000, 16'h0040, 1, 18, 2'd0, 1, 1, 0);
      xfer("set_addr", 8'h00, 8'h05, 16'h0023, 16'h0000, 16'h0000, 0, 0, 2'd0, 1, 1, 0);
      chk("dev_addr", dev_addr, 7'h23);
      xfer("get_cfg9", 8'h80, 8'h06, 16'h0200, 16'h0000, 16'h0009, 2, 9, 2'd0, 1, 1, 0);
      xfer("unsupp", 8'h80, 8'h01, 16'h0000, 16'h0000, 16'h0000, 0, 0, 2'd3, 0, 1, 0);

      block_rdy = 1'b1;
      xfer("no_ready", 8'h80, 8'h06, 16'h0100, 16'h0000, 16'h0040, 0, 0, 2'd1, 0, 0, 1);
      block_rdy = 1'b0;

      // abort during READ once byte 5 has been delivered
      push_exp(8'h80, 8'h06, 16'h0100, 16'h0000, 16'h0040, 1, 6, 1);
      d0 = done_seen;
      r0 = rsp_seen;
      pulse(8'h80, 8'h06, 16'h0100, 16'h0000, 16'h0040);
      for (int c = 0; c < 500; c++) begin
         @(negedge phy_clk); #1;
         if (rsp_seen >= r0 + 6) break;
      end
      chk("abort_reached_b5", rsp_seen - r0, 6);
      #2 reset = 1'b1;
      #1 check_zero("abort");
      repeat (2) @(posedge phy_clk);
      #1 reset = 1'b0;
      repeat (20) @(posedge phy_clk);
      chk("abort_no_done", done_seen - d0, 0);

      xfer("after_abort", 8'h80, 8'h06, 16'h0100, 16'h0000, 16'h0040, 1, 18, 2'd0, 1, 1, 0);

      chk("wr_q_empty", exp_wr.size(), 0);
      chk("rsp_q_empty", exp_rsp.size(), 0);
      chk("done_q_empty", exp_done.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
